decode_stage: RTL and testbench
===============================

# decode_stage

Buffered, handshaked RV32I decode stage that replaces the combinational decoder between fetch and register read. It accepts `{pc, instr}` pairs from fetch over a valid/ready interface, queues them in a `DEPTH`-entry buffer, and emits a registered decode bundle. The bundle carries register addresses, function fields, immediate, immediate type and an illegal flag. The block sustains one instruction per cycle, absorbs downstream stalls, and supports a pipeline flush for branch redirects.

## Interface
- `DEPTH`, 2, input queue entries; power of two, ≥ 2.
- `NUM_REGS`, 32, architectural register count; 32 for RV32I, 16 for RV32E.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset; one clock, reset is synchronous and active-high.
- `flush_i`  in  1  discard all queued and output-held instructions.
- `in_valid_i`  in  1  fetch presents `pc_i`/`instr_i`.
- `in_ready_o`  out  1  stage can accept.
- `pc_i`  in  `nebula::word_t`  instruction address.
- `instr_i`  in  `nebula::word_t`  instruction word.
- `out_valid_o`  out  1  decode bundle valid.
- `out_ready_i`  in  1  consumer accepts bundle.
- `out_pc_o`  out  `word_t`  PC of bundle.
- `opcode_o`  out  7  `instr[6:0]`.
- `addr_rd_o`, `addr_rs1_o`, `addr_rs2_o`  out  5 each  `instr[11:7]`, `[19:15]`, `[24:20]`.
- `funct3_o`  out  3  `instr[14:12]`.
- `funct7_o`  out  7  `instr[31:25]`.
- `imm_type_o`  out  `nebula::imm_t`  selected immediate format.
- `imm_o`  out  `word_t`  sign-extended immediate, produced by existing `imm_gen`.
- `illegal_o`  out  1  instruction flagged illegal (see Configuration).

## Operation
- Input transfer when `in_valid_i && in_ready_o`; output transfer when `out_valid_o && out_ready_i`.
- Queue: circular buffer with read and write pointers of `$clog2(DEPTH)` bits, plus a count of `$clog2(DEPTH+1)` bits. Pointers wrap modulo `DEPTH`.
- Output register is free when `!out_valid_o || out_ready_i`.
- Load source for the output register, evaluated whenever it is free:
  - queue non-empty → queue head;
  - else input transfer this cycle → input directly (bypass; the entry is not written to the queue);
  - else `out_valid_o` ← 0.
- Input is written to the queue unless it was bypassed.
- `in_ready_o = !rst_i && !flush_i && count < DEPTH`. There is no pass-through when full: a pop in the same cycle does not raise ready.
- Decode is combinational on the selected source and registered into the output fields.
- Immediate type by opcode:
  - `opcodes::Store` → `s_type`;
  - `Branch` → `b_type`;
  - `AuiPc`, `Lui` → `u_type`;
  - `Jal` → `j_type`;
  - all others → `i_type`.
- Output fields hold their value while `out_valid_o && !out_ready_i`. Values are don't-care when `out_valid_o` = 0.

## Timing
- Reset:
  - count, pointers and `out_valid_o` = 0;
  - all output data fields = 0;
  - `in_ready_o` = 0 while `rst_i` is high, 1 on the first cycle after.
- Latency:
  - instruction accepted at edge N with queue empty and output free → `out_valid_o` = 1 after edge N.
  - Otherwise it appears once every older entry has drained.
- Throughput: 1 instruction/cycle with `out_ready_i` held high.
- Flush, synchronous:
  - at the edge where `flush_i` = 1, count and pointers reset and `out_valid_o` ← 0;
  - input is not accepted that cycle;
  - an output transfer coincident with the flush still completes for the consumer.
- Reset or flush mid-stall discards held data; no partial bundle is emitted afterwards.
- Full queue and stalled output: `in_ready_o` = 0 and the queue is unchanged.
- Simultaneous push and pop with the queue non-empty: count unchanged, both pointers advance.

## Configuration
- `DECODE_ILLEGAL_CHECK_EN` defined: `illegal_o` = 1 when any of the following holds:
  - `instr[1:0]` ≠ 2'b11;
  - opcode is not one of Lui, AuiPc, Jal, Jalr, Branch, Load, Store, OpImm, Op, MiscMem, System;
  - any of rd/rs1/rs2 ≥ `NUM_REGS`, checked for all formats.
  
  Illegal instructions still flow through the stage with all fields populated.
- Not defined: `illegal_o` is constant 0 and no check logic is synthesised.

## Test plan
- Reset then a single push of `pc=0x100`, `instr=0x00500093` (addi x1,x0,5), `out_ready_i`=1 → next cycle: `out_valid_o`=1, rd=1, rs1=0, `imm_o`=5, `imm_type_o`=`i_type`, `illegal_o`=0.
- Hold `out_ready_i`=0 and push `DEPTH`+1 instructions → `in_ready_o` drops after `DEPTH`+1 accepts (`DEPTH` queued + 1 output). Release ready → bundles emerge in order with unchanged PCs.
- Push `0xFE000EE3` (beq, offset −4) then `0x000012B7` (lui x5,1) back to back → `imm_o`=0xFFFFFFFC (`b_type`), then `0x00001000` (`u_type`), on consecutive cycles.
- Fill the queue to 2 entries and assert `flush_i` for one cycle → next cycle `out_valid_o`=0 and count=0. A subsequent push appears after 1 cycle.
- With `DECODE_ILLEGAL_CHECK_EN` and `NUM_REGS`=16: `0x01000813` (addi x16) → `illegal_o`=1. Push `0xFFFFFFFF` → `illegal_o`=1. Without the macro, both cases give `illegal_o`=0.
- Randomised `in_valid_i`/`out_ready_i` over 1000 instructions → the output sequence equals the input sequence, with no drops or duplicates.

Source files
------------

// File: rtl/decode_stage_if.sv
// decode_stage_if: shared word/immediate types, RV32I major opcodes and the decode stage handshake bundle.
// The packages sit ahead of the interface so that the interface and the stage can both see them.
// slave is the decode stage's view of the bundle; master is the view from fetch and the consumer.
package nebula;
  typedef logic [31:0] word_t;
  typedef enum logic [2:0] {
    i_type = 3'd0,
    s_type = 3'd1,
    b_type = 3'd2,
    u_type = 3'd3,
    j_type = 3'd4
  } imm_t;
endpackage

package opcodes;
  localparam logic [6:0] Lui     = 7'b0110111;
  localparam logic [6:0] AuiPc   = 7'b0010111;
  localparam logic [6:0] Jal     = 7'b1101111;
  localparam logic [6:0] Jalr    = 7'b1100111;
  localparam logic [6:0] Branch  = 7'b1100011;
  localparam logic [6:0] Load    = 7'b0000011;
  localparam logic [6:0] Store   = 7'b0100011;
  localparam logic [6:0] OpImm   = 7'b0010011;
  localparam logic [6:0] Op      = 7'b0110011;
  localparam logic [6:0] MiscMem = 7'b0001111;
  localparam logic [6:0] System  = 7'b1110011;
endpackage

interface decode_stage_if;
  // fetch side
  logic          in_valid_i;
  logic          in_ready_o;
  nebula::word_t pc_i;
  nebula::word_t instr_i;
  // consumer side
  logic          out_valid_o;
  logic          out_ready_i;
  nebula::word_t out_pc_o;
  logic [6:0]    opcode_o;
  logic [4:0]    addr_rd_o;
  logic [4:0]    addr_rs1_o;
  logic [4:0]    addr_rs2_o;
  logic [2:0]    funct3_o;
  logic [6:0]    funct7_o;
  nebula::imm_t  imm_type_o;
  nebula::word_t imm_o;
  logic          illegal_o;

  modport slave (
    input  in_valid_i, pc_i, instr_i, out_ready_i,
    output in_ready_o, out_valid_o, out_pc_o, opcode_o, addr_rd_o, addr_rs1_o, addr_rs2_o,
           funct3_o, funct7_o, imm_type_o, imm_o, illegal_o
  );

  modport master (
    output in_valid_i, pc_i, instr_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_pc_o, opcode_o, addr_rd_o, addr_rs1_o, addr_rs2_o,
           funct3_o, funct7_o, imm_type_o, imm_o, illegal_o
  );
endinterface

// File: rtl/decode_stage.sv
// decode_stage: queued RV32I decoder between fetch and register read; optional illegal check under DECODE_ILLEGAL_CHECK_EN.
// Latency: 1 cycle when queue is empty and the output register is free (input bypasses the queue), else after older entries drain.
// Backpressure: DEPTH-entry queue plus one output register absorb stalls; in_ready drops when the queue is full or on flush/reset.

module imm_gen (
  input  logic [31:7]   instr_i,
  input  nebula::imm_t  imm_type_i,
  output nebula::word_t imm_o
);
  // Reassemble and sign-extend the immediate for the selected format
  always_comb begin
    imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
    case (imm_type_i)
      nebula::s_type: imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      nebula::b_type: imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
      nebula::u_type: imm_o = {instr_i[31:12], 12'b0};
      nebula::j_type: imm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
      default:        ;
    endcase
  end
endmodule

module decode_stage #(
  parameter int DEPTH    = 2,
  parameter int NUM_REGS = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush_i,
  decode_stage_if.slave dec_if
);
  import nebula::*;

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("decode_stage: DEPTH must be a power of two >= 2");
  end
  if (NUM_REGS < 1 || NUM_REGS > 32) begin : g_bad_regs
    $error("decode_stage: NUM_REGS must be in 1..32");
  end

  word_t         pc_mem_q    [DEPTH];
  word_t         instr_mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q;

  logic          out_valid_q;
  word_t         out_pc_q, imm_q;
  logic [6:0]    opcode_q, funct7_q;
  logic [4:0]    rd_q, rs1_q, rs2_q;
  logic [2:0]    funct3_q;
  imm_t          imm_type_q;

  logic          in_ready, push, out_free, q_empty, pop, bypass, wr_en, load;
  word_t         sel_pc, sel_instr, imm_d;
  imm_t          imm_type_d;

  // A pop in the same cycle never frees a slot for the input: ready looks only at the registered count.
  assign in_ready  = !rst_i && !flush_i && (count_q < CW'(DEPTH));
  assign push      = dec_if.in_valid_i && in_ready;
  assign out_free  = !out_valid_q || dec_if.out_ready_i;
  assign q_empty   = (count_q == '0);
  assign pop       = out_free && !q_empty;
  assign bypass    = out_free && q_empty && push;
  assign wr_en     = push && !bypass;
  assign load      = pop || bypass;
  assign sel_pc    = q_empty ? dec_if.pc_i    : pc_mem_q[rd_ptr_q];
  assign sel_instr = q_empty ? dec_if.instr_i : instr_mem_q[rd_ptr_q];

  // Immediate format chosen from the major opcode of the selected instruction
  always_comb begin
    imm_type_d = i_type;
    case (sel_instr[6:0])
      opcodes::Store:              imm_type_d = s_type;
      opcodes::Branch:             imm_type_d = b_type;
      opcodes::AuiPc, opcodes::Lui: imm_type_d = u_type;
      opcodes::Jal:                imm_type_d = j_type;
      default:                     ;
    endcase
  end

  imm_gen u_imm_gen (
    .instr_i    (sel_instr[31:7]),
    .imm_type_i (imm_type_d),
    .imm_o      (imm_d)
  );

  // Queue storage; written only when the input is not bypassed straight to the output
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      pc_mem_q[wr_ptr_q]    <= dec_if.pc_i;
      instr_mem_q[wr_ptr_q] <= dec_if.instr_i;
    end
  end

  // Queue pointers/count and the registered decode bundle
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_pc_q    <= '0;
      opcode_q    <= '0;
      rd_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      funct3_q    <= '0;
      funct7_q    <= '0;
      imm_type_q  <= i_type;
      imm_q       <= '0;
    end else if (flush_i) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + PW'(1);
      if (wr_en && !pop)      count_q <= count_q + CW'(1);
      else if (pop && !wr_en) count_q <= count_q - CW'(1);
      if (out_free) out_valid_q <= load;
      if (load) begin
        out_pc_q   <= sel_pc;
        opcode_q   <= sel_instr[6:0];
        rd_q       <= sel_instr[11:7];
        rs1_q      <= sel_instr[19:15];
        rs2_q      <= sel_instr[24:20];
        funct3_q   <= sel_instr[14:12];
        funct7_q   <= sel_instr[31:25];
        imm_type_q <= imm_type_d;
        imm_q      <= imm_d;
      end
    end
  end

`ifdef DECODE_ILLEGAL_CHECK_EN
  localparam logic [5:0] NREG = 6'(NUM_REGS);
  logic illegal_d, illegal_q, known_op;

  // Flag bad compressed-quadrant bits, unknown opcodes and register indices beyond the register file
  always_comb begin
    known_op  = sel_instr[6:0] inside {opcodes::Lui, opcodes::AuiPc, opcodes::Jal, opcodes::Jalr,
                                       opcodes::Branch, opcodes::Load, opcodes::Store, opcodes::OpImm,
                                       opcodes::Op, opcodes::MiscMem, opcodes::System};
    illegal_d = (sel_instr[1:0] != 2'b11) || !known_op ||
                ({1'b0, sel_instr[11:7]}  >= NREG) ||
                ({1'b0, sel_instr[19:15]} >= NREG) ||
                ({1'b0, sel_instr[24:20]} >= NREG);
  end

  // Illegal flag travels with the rest of the bundle
  always_ff @(posedge clk_i) begin
    if (rst_i)                  illegal_q <= 1'b0;
    else if (!flush_i && load)  illegal_q <= illegal_d;
  end

  assign dec_if.illegal_o = illegal_q;
`else
  assign dec_if.illegal_o = 1'b0;
`endif

  assign dec_if.in_ready_o  = in_ready;
  assign dec_if.out_valid_o = out_valid_q;
  assign dec_if.out_pc_o    = out_pc_q;
  assign dec_if.opcode_o    = opcode_q;
  assign dec_if.addr_rd_o   = rd_q;
  assign dec_if.addr_rs1_o  = rs1_q;
  assign dec_if.addr_rs2_o  = rs2_q;
  assign dec_if.funct3_o    = funct3_q;
  assign dec_if.funct7_o    = funct7_q;
  assign dec_if.imm_type_o  = imm_type_q;
  assign dec_if.imm_o       = imm_q;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: scenario tasks plus a negedge scoreboard monitor for decode_stage (DEPTH=2, NUM_REGS=16).
// Expected bundles come from a reference decode model applied to every accepted input.
// Inputs are driven 1ns after the rising edge; outputs are sampled on the falling edge.
`timescale 1ns/1ps
module tb_decode_stage;
  import nebula::*;

  localparam int DEPTH    = 2;
  localparam int NUM_REGS = 16;
`ifdef DECODE_ILLEGAL_CHECK_EN
  localparam bit ILL_EN = 1'b1;
`else
  localparam bit ILL_EN = 1'b0;
`endif

  typedef struct packed {
    word_t      pc;
    logic [6:0] opc;
    logic [4:0] rd, rs1, rs2;
    logic [2:0] f3;
    logic [6:0] f7;
    imm_t       it;
    word_t      imm;
    logic       ill;
  } bundle_t;

  logic clk = 1'b0;
  logic rst, flush;
  int   total = 0, bad = 0;
  int   n_in = 0, n_out = 0;
  bundle_t sb[$];

  decode_stage_if bus();

  decode_stage #(.DEPTH(DEPTH), .NUM_REGS(NUM_REGS)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .flush_i (flush),
    .dec_if  (bus)
  );

  always #5 clk = ~clk;

  function automatic bundle_t model(input word_t pc, input word_t ins);
    bundle_t b;
    int v;
    logic [6:0] op;
    op    = ins[6:0];
    b.pc  = pc;  b.opc = op;
    b.rd  = ins[11:7];  b.rs1 = ins[19:15];  b.rs2 = ins[24:20];
    b.f3  = ins[14:12]; b.f7  = ins[31:25];
    if (op == 7'h23)                    b.it = s_type;
    else if (op == 7'h63)               b.it = b_type;
    else if (op == 7'h37 || op == 7'h17) b.it = u_type;
    else if (op == 7'h6F)               b.it = j_type;
    else                                b.it = i_type;
    case (b.it)
      s_type:  begin v = $signed({ins[31:25], ins[11:7]}); b.imm = v; end
      b_type:  begin v = $signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}); b.imm = v; end
      u_type:  b.imm = ins & 32'hFFFF_F000;
      j_type:  begin v = $signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}); b.imm = v; end
      default: begin v = $signed(ins[31:20]); b.imm = v; end
    endcase
    b.ill = ILL_EN && ((ins[1:0] != 2'b11) ||
            !(op inside {7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73}) ||
            (int'(b.rd) >= NUM_REGS) || (int'(b.rs1) >= NUM_REGS) || (int'(b.rs2) >= NUM_REGS));
    return b;
  endfunction

  // Scoreboard: pop and compare on output transfers, push on input transfers, drop all on flush/reset
  always @(negedge clk) begin : monitor
    bundle_t act, expv;
    if (rst) begin
      sb.delete();
    end else begin
      if (bus.out_valid_o && bus.out_ready_i) begin
        act = '{pc: bus.out_pc_o, opc: bus.opcode_o, rd: bus.addr_rd_o, rs1: bus.addr_rs1_o,
                rs2: bus.addr_rs2_o, f3: bus.funct3_o, f7: bus.funct7_o, it: bus.imm_type_o,
                imm: bus.imm_o, ill: bus.illegal_o};
        total++; n_out++;
        if (sb.size() == 0) begin
          bad++; $display("FAIL sb_underflow got pc=%h with nothing outstanding", act.pc);
        end else begin
          expv = sb.pop_front();
          if (act !== expv) begin
            bad++; $display("FAIL sb_bundle got=%h want=%h", act, expv);
          end
        end
      end
      if (bus.in_valid_i && bus.in_ready_o) begin
        sb.push_back(model(bus.pc_i, bus.instr_i));
        n_in++;
      end
      if (flush) sb.delete();
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  // Present one instruction and wait (bounded) for it to be accepted; leaves in_valid asserted.
  task automatic push(input word_t pc, input word_t ins);
    int w;
    w = 0;
    bus.in_valid_i = 1'b1; bus.pc_i = pc; bus.instr_i = ins;
    @(negedge clk);
    while (!bus.in_ready_o && w < 100) begin w++; @(negedge clk); end
    if (!bus.in_ready_o) begin total++; bad++; $display("FAIL push_timeout pc=%h", pc); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0;
    bus.in_valid_i = 1'b0; bus.out_ready_i = 1'b0; bus.pc_i = '0; bus.instr_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (bus.in_ready_o !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b want=0", bus.in_ready_o); end
    total++; if (bus.out_valid_o !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b want=0", bus.out_valid_o); end
    total++;
    if ({bus.out_pc_o, bus.opcode_o, bus.addr_rd_o, bus.addr_rs1_o, bus.addr_rs2_o, bus.funct3_o,
         bus.funct7_o, bus.imm_type_o, bus.imm_o, bus.illegal_o} !== '0) begin
      bad++; $display("FAIL rst_fields got pc=%h imm=%h opc=%h want all zero", bus.out_pc_o, bus.imm_o, bus.opcode_o);
    end
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    total++; if (bus.in_ready_o !== 1'b1) begin bad++; $display("FAIL post_rst_in_ready got=%b want=1", bus.in_ready_o); end
    total++; if (bus.out_valid_o !== 1'b0) begin bad++; $display("FAIL post_rst_out_valid got=%b want=0", bus.out_valid_o); end
    cyc();
  endtask

  task automatic test_single();
    bus.out_ready_i = 1'b1;
    push(32'h100, 32'h0050_0093);
    bus.in_valid_i = 1'b0;
    @(negedge clk);
    total++; if (bus.out_valid_o !== 1'b1) begin bad++; $display("FAIL single_valid got=%b want=1", bus.out_valid_o); end
    total++; if (bus.out_pc_o !== 32'h100) begin bad++; $display("FAIL single_pc got=%h want=100", bus.out_pc_o); end
    total++; if (bus.addr_rd_o !== 5'd1 || bus.addr_rs1_o !== 5'd0) begin bad++; $display("FAIL single_regs got rd=%0d rs1=%0d want 1,0", bus.addr_rd_o, bus.addr_rs1_o); end
    total++; if (bus.imm_o !== 32'd5 || bus.imm_type_o !== i_type) begin bad++; $display("FAIL single_imm got=%h/%0d want 5/i_type", bus.imm_o, bus.imm_type_o); end
    total++; if (bus.illegal_o !== 1'b0) begin bad++; $display("FAIL single_illegal got=%b want=0", bus.illegal_o); end
    cyc();
    @(negedge clk);
    total++; if (bus.out_valid_o !== 1'b0) begin bad++; $display("FAIL single_drained got=%b want=0", bus.out_valid_o); end
    cyc();
  endtask

  task automatic test_full_stall();
    word_t ins;
    bus.out_ready_i = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      ins = 32'h0000_0013 | (word_t'(i + 1) << 7);
      push(32'h1000 + word_t'(i * 4), ins);
    end
    bus.pc_i = 32'h2000; bus.instr_i = 32'h0000_0313;   // held, must wait for room
    @(negedge clk);
    total++; if (bus.in_ready_o !== 1'b0) begin bad++; $display("FAIL full_in_ready got=%b want=0", bus.in_ready_o); end
    total++; if (bus.out_valid_o !== 1'b1 || bus.out_pc_o !== 32'h1000) begin bad++; $display("FAIL full_head got v=%b pc=%h want 1/1000", bus.out_valid_o, bus.out_pc_o); end
    cyc();
    bus.out_ready_i = 1'b1;
    @(negedge clk);
    total++; if (bus.in_ready_o !== 1'b0) begin bad++; $display("FAIL full_no_passthru got=%b want=0", bus.in_ready_o); end
    cyc();
    @(negedge clk);
    total++; if (bus.out_pc_o !== 32'h1004 || bus.in_ready_o !== 1'b1) begin bad++; $display("FAIL full_drain1 got pc=%h rdy=%b want 1004/1", bus.out_pc_o, bus.in_ready_o); end
    cyc();
    bus.in_valid_i = 1'b0;
    @(negedge clk);
    total++; if (bus.out_pc_o !== 32'h1008) begin bad++; $display("FAIL full_drain2 got pc=%h want=1008", bus.out_pc_o); end
    cyc();
    @(negedge clk);
    total++; if (bus.out_pc_o !== 32'h2000) begin bad++; $display("FAIL full_drain3 got pc=%h want=2000", bus.out_pc_o); end
    cyc();
    @(negedge clk);
    total++; if (bus.out_valid_o !== 1'b0) begin bad++; $display("FAIL full_empty got=%b want=0", bus.out_valid_o); end
    cyc();
  endtask

  task automatic test_back_to_back();
    bus.out_ready_i = 1'b1;
    bus.in_valid_i = 1'b1; bus.pc_i = 32'h200; bus.instr_i = 32'hFE00_0EE3;
    @(negedge clk);
    total++; if (bus.in_ready_o !== 1'b1) begin bad++; $display("FAIL b2b_ready got=%b want=1", bus.in_ready_o); end
    cyc();
    bus.pc_i = 32'h204; bus.instr_i = 32'h0000_12B7;
    @(negedge clk);
    total++; if (bus.out_pc_o !== 32'h200 || bus.imm_o !== 32'hFFFF_FFFC || bus.imm_type_o !== b_type) begin
      bad++; $display("FAIL b2b_beq got pc=%h imm=%h type=%0d want 200/fffffffc/b_type", bus.out_pc_o, bus.imm_o, bus.imm_type_o);
    end
    cyc();
    bus.in_valid_i = 1'b0;
    @(negedge clk);
    total++; if (bus.out_pc_o !== 32'h204 || bus.imm_o !== 32'h0000_1000 || bus.imm_type_o !== u_type || bus.addr_rd_o !== 5'd5) begin
      bad++; $display("FAIL b2b_lui got pc=%h imm=%h type=%0d rd=%0d want 204/1000/u_type/5", bus.out_pc_o, bus.imm_o, bus.imm_type_o, bus.addr_rd_o);
    end
    cyc();
  endtask

  task automatic test_flush();
    bus.out_ready_i = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) push(32'h3000 + word_t'(i * 4), 32'h0000_0013);
    flush = 1'b1; bus.out_ready_i = 1'b1;
    bus.pc_i = 32'h3100;                         // offered during flush, must be refused
    @(negedge clk);
    total++; if (bus.in_ready_o !== 1'b0) begin bad++; $display("FAIL flush_in_ready got=%b want=0", bus.in_ready_o); end
    cyc();
    flush = 1'b0; bus.in_valid_i = 1'b0; bus.out_ready_i = 1'b0;
    @(negedge clk);
    total++; if (bus.out_valid_o !== 1'b0 || bus.in_ready_o !== 1'b1) begin bad++; $display("FAIL flush_cleared got v=%b rdy=%b want 0/1", bus.out_valid_o, bus.in_ready_o); end
    cyc();
    @(negedge clk);
    total++; if (bus.out_valid_o !== 1'b0) begin bad++; $display("FAIL flush_residue got=%b want=0", bus.out_valid_o); end
    bus.out_ready_i = 1'b1;
    cyc();
    push(32'h3200, 32'h0070_0113);
    bus.in_valid_i = 1'b0;
    @(negedge clk);
    total++; if (bus.out_valid_o !== 1'b1 || bus.out_pc_o !== 32'h3200) begin bad++; $display("FAIL flush_next got v=%b pc=%h want 1/3200", bus.out_valid_o, bus.out_pc_o); end
    cyc();
  endtask

  task automatic test_reset_midstall();
    bus.out_ready_i = 1'b0;
    push(32'h5000, 32'h0000_0013);
    push(32'h5004, 32'h0000_0013);
    bus.in_valid_i = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    total++; if (bus.in_ready_o !== 1'b0) begin bad++; $display("FAIL rst_stall_ready got=%b want=0", bus.in_ready_o); end
    cyc();
    rst = 1'b0; bus.out_ready_i = 1'b1;
    @(negedge clk);
    total++; if (bus.out_valid_o !== 1'b0 || bus.out_pc_o !== 32'h0) begin bad++; $display("FAIL rst_stall_clear got v=%b pc=%h want 0/0", bus.out_valid_o, bus.out_pc_o); end
    cyc();
  endtask

  task automatic test_illegal();
    bus.out_ready_i = 1'b1;
    bus.in_valid_i = 1'b1; bus.pc_i = 32'h400; bus.instr_i = 32'h0100_0813;
    cyc();
    bus.pc_i = 32'h404; bus.instr_i = 32'hFFFF_FFFF;
    @(negedge clk);
    total++; if (bus.addr_rd_o !== 5'd16 || bus.illegal_o !== ILL_EN) begin bad++; $display("FAIL illegal_rd16 got rd=%0d ill=%b want 16/%b", bus.addr_rd_o, bus.illegal_o, ILL_EN); end
    cyc();
    bus.in_valid_i = 1'b0;
    @(negedge clk);
    total++; if (bus.opcode_o !== 7'h7F || bus.illegal_o !== ILL_EN) begin bad++; $display("FAIL illegal_ones got opc=%h ill=%b want 7f/%b", bus.opcode_o, bus.illegal_o, ILL_EN); end
    cyc();
  endtask

  task automatic test_random();
    logic [6:0] ops [11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};
    int sent, guard, in0, out0;
    bit acc;
    word_t w;
    sent = 0; guard = 0; in0 = n_in; out0 = n_out;
    bus.in_valid_i = 1'b0;
    while (sent < 1000 && guard < 20000) begin
      if (!bus.in_valid_i && $urandom_range(3) != 0) begin
        w = $urandom;
        if ($urandom_range(1) != 0) w[6:0] = ops[$urandom_range(10)];
        bus.in_valid_i = 1'b1; bus.pc_i = 32'h10000 + word_t'(sent * 4); bus.instr_i = w;
      end
      bus.out_ready_i = ($urandom_range(3) != 0);
      @(negedge clk);
      acc = bus.in_valid_i && bus.in_ready_o;
      cyc(); guard++;
      if (acc) begin sent++; bus.in_valid_i = 1'b0; end
    end
    bus.in_valid_i = 1'b0; bus.out_ready_i = 1'b1;
    guard = 0;
    while (sb.size() != 0 && guard < 100) begin cyc(); guard++; end
    @(negedge clk);
    total++; if (sent != 1000) begin bad++; $display("FAIL rand_sent got=%0d want=1000", sent); end
    total++; if ((n_out - out0) != (n_in - in0)) begin bad++; $display("FAIL rand_counts got out=%0d want in=%0d", n_out - out0, n_in - in0); end
    total++; if (sb.size() != 0) begin bad++; $display("FAIL rand_leftover got=%0d want=0", sb.size()); end
    cyc();
  endtask

  initial begin
    test_reset();
    test_single();
    test_full_stall();
    test_back_to_back();
    test_flush();
    test_reset_midstall();
    test_illegal();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
